// File: rtl/eql_pkg.sv
// Shared width helpers for index and count fields sized from an entry count.
// Latency: none (elaboration-time functions only).
// Backpressure: not applicable.
package eql_pkg;

  // Bits needed to address depth entries (at least one bit).
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Bits needed to hold a count from 0 up to and including depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/eql_cmp.sv
// Equality comparator between a stored entry and a search key.
// Latency: combinational.
// Backpressure: not applicable.
module eql_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_dat,
  input  logic [WIDTH-1:0] b_dat,
  output logic             eq
);

  assign eq = (a_dat == b_dat);

endmodule

// File: rtl/eql_cam.sv
// Small register CAM: per-entry valid bits, equality search with lowest-index priority.
// Latency: one cycle from search transfer to registered response.
// Backpressure: srh_rdy drops while a response is held with rsp_rdy low; response outputs hold.
module eql_cam
  import eql_pkg::*;
#(
  parameter int  WIDTH = 4,
  parameter int  DEPTH = 8,
  localparam int IDX_W = idx_w(DEPTH),
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             clr,
  input  logic             srh_vld,
  output logic             srh_rdy,
  input  logic [WIDTH-1:0] srh_dat,
  output logic             rsp_vld,
  input  logic             rsp_rdy,
  output logic             rsp_hit,
  output logic [IDX_W-1:0] rsp_idx,
  output logic [DEPTH-1:0] rsp_msk,
  output logic [CNT_W-1:0] cnt
);

  logic [WIDTH-1:0] ent_q [DEPTH];
  logic [WIDTH-1:0] ent_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             rsp_vld_q, rsp_vld_d;
  logic             rsp_hit_q, rsp_hit_d;
  logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;
  logic [DEPTH-1:0] rsp_msk_q, rsp_msk_d;

  logic             wr_en;
  logic             srh_fire;
  logic [DEPTH-1:0] cmp_eq;
  logic [DEPTH-1:0] match;
  logic [IDX_W-1:0] match_idx;

  // Writes outside the populated range are dropped; writes during reset are ignored too.
  assign wr_en = wr_vld && (32'(wr_idx) < DEPTH) && !rst;

  // Searches see the pre-edge table, so same-cycle writes/clears never leak into a result.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    eql_cmp #(.WIDTH(WIDTH)) u_cmp (
      .a_dat (ent_q[i]),
      .b_dat (srh_dat),
      .eq    (cmp_eq[i])
    );
  end

  assign match    = cmp_eq & vld_q;
  assign srh_rdy  = !rsp_vld_q || rsp_rdy;
  assign srh_fire = srh_vld && srh_rdy;

  // Lowest matching index wins; a miss encodes as index 0.
  always_comb begin
    match_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) match_idx = IDX_W'(i);
    end
  end

  // Next table state: clear first, then the same-cycle write survives it.
  always_comb begin
    ent_d = ent_q;
    vld_d = clr ? '0 : vld_q;
    if (wr_en) begin
      ent_d[wr_idx] = wr_dat;
      vld_d[wr_idx] = 1'b1;
    end
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + CNT_W'(vld_d[i]);
    end
  end

  // Response register: load on transfer, drop on consume, otherwise hold.
  always_comb begin
    rsp_vld_d = rsp_vld_q;
    rsp_hit_d = rsp_hit_q;
    rsp_idx_d = rsp_idx_q;
    rsp_msk_d = rsp_msk_q;
    if (srh_fire) begin
      rsp_vld_d = 1'b1;
      rsp_hit_d = |match;
      rsp_idx_d = match_idx;
      rsp_msk_d = match;
    end else if (rsp_rdy) begin
      rsp_vld_d = 1'b0;
    end
  end

  // Entry payloads carry no reset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      cnt_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_hit_q <= 1'b0;
      rsp_idx_q <= '0;
      rsp_msk_q <= '0;
    end else begin
      vld_q     <= vld_d;
      cnt_q     <= cnt_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_hit_q <= rsp_hit_d;
      rsp_idx_q <= rsp_idx_d;
      rsp_msk_q <= rsp_msk_d;
    end
  end

  assign rsp_vld = rsp_vld_q;
  assign rsp_hit = rsp_hit_q;
  assign rsp_idx = rsp_idx_q;
  assign rsp_msk = rsp_msk_q;
  assign cnt     = cnt_q;

endmodule

// File: tb/tb_eql_cam.sv
// Directed and randomized checks of eql_cam with default WIDTH=4, DEPTH=8.
// Inputs change 1 time unit after the rising edge; outputs are sampled then.
// A software table and response tracker supply expected values in the random phase.
module tb_eql_cam;

  logic       clk;
  logic       rst;
  logic       wr_vld;
  logic [2:0] wr_idx;
  logic [3:0] wr_dat;
  logic       clr;
  logic       srh_vld;
  logic       srh_rdy;
  logic [3:0] srh_dat;
  logic       rsp_vld;
  logic       rsp_rdy;
  logic       rsp_hit;
  logic [2:0] rsp_idx;
  logic [7:0] rsp_msk;
  logic [3:0] cnt;

  int n_err = 0;
  int n_chk = 0;

  // software model for the random phase
  logic [3:0] m_ent [8];
  logic [7:0] m_vld;
  logic       e_vld;
  logic       e_hit;
  logic [2:0] e_idx;
  logic [7:0] e_msk;
  logic       fire;
  int         pop;

  eql_cam #(.WIDTH(4), .DEPTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_vld  (wr_vld),
    .wr_idx  (wr_idx),
    .wr_dat  (wr_dat),
    .clr     (clr),
    .srh_vld (srh_vld),
    .srh_rdy (srh_rdy),
    .srh_dat (srh_dat),
    .rsp_vld (rsp_vld),
    .rsp_rdy (rsp_rdy),
    .rsp_hit (rsp_hit),
    .rsp_idx (rsp_idx),
    .rsp_msk (rsp_msk),
    .cnt     (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_vld  = 1'b0;
    wr_idx  = '0;
    wr_dat  = '0;
    clr     = 1'b0;
    srh_vld = 1'b0;
    srh_dat = '0;
  endtask

  initial begin
    rst = 1'b1;
    rsp_rdy = 1'b1;
    idle();
    tick();
    tick();
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_hit", rsp_hit, 0);
    chk("rst_idx", rsp_idx, 0);
    chk("rst_msk", rsp_msk, 0);
    rst = 1'b0;
    #1;
    chk("rst_srh_rdy", srh_rdy, 1);

    // empty table search misses
    srh_vld = 1'b1; srh_dat = 4'h5;
    tick();
    idle();
    chk("empty_vld", rsp_vld, 1);
    chk("empty_hit", rsp_hit, 0);
    chk("empty_idx", rsp_idx, 0);
    chk("empty_msk", rsp_msk, 0);
    chk("empty_cnt", cnt, 0);
    tick();
    chk("empty_drop", rsp_vld, 0);

    // two matching entries, lowest index reported
    wr_vld = 1'b1; wr_idx = 3'd2; wr_dat = 4'hA;
    tick();
    wr_idx = 3'd6;
    tick();
    idle();
    chk("two_cnt", cnt, 2);
    srh_vld = 1'b1; srh_dat = 4'hA;
    tick();
    idle();
    chk("two_vld", rsp_vld, 1);
    chk("two_hit", rsp_hit, 1);
    chk("two_idx", rsp_idx, 2);
    chk("two_msk", rsp_msk, 8'b0100_0100);

    // read-before-write: same-cycle write is invisible, next search sees it
    wr_vld = 1'b1; wr_idx = 3'd3; wr_dat = 4'h7;
    srh_vld = 1'b1; srh_dat = 4'h7;
    tick();
    wr_vld = 1'b0;
    chk("rbw_hit", rsp_hit, 0);
    chk("rbw_msk", rsp_msk, 0);
    chk("rbw_cnt", cnt, 3);
    tick();
    idle();
    chk("rbw2_hit", rsp_hit, 1);
    chk("rbw2_idx", rsp_idx, 3);
    chk("rbw2_msk", rsp_msk, 8'h08);
    tick();
    chk("rbw_drop", rsp_vld, 0);

    // backpressure: hold A response for 3 cycles while a 7 search waits
    rsp_rdy = 1'b0;
    srh_vld = 1'b1; srh_dat = 4'hA;
    tick();
    srh_dat = 4'h7;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_srh_rdy", srh_rdy, 0);
      chk("bp_vld", rsp_vld, 1);
      chk("bp_msk", rsp_msk, 8'h44);
      chk("bp_idx", rsp_idx, 2);
      tick();
    end
    rsp_rdy = 1'b1;
    #1;
    chk("bp_release_rdy", srh_rdy, 1);
    tick();
    idle();
    chk("bp_next_vld", rsp_vld, 1);
    chk("bp_next_msk", rsp_msk, 8'h08);
    chk("bp_next_idx", rsp_idx, 3);
    tick();
    chk("bp_no_dup", rsp_vld, 0);

    // fill all entries: 8,9,A,B,8,9,A,B
    for (int i = 0; i < 8; i++) begin
      wr_vld = 1'b1; wr_idx = 3'(i); wr_dat = 4'(8 + (i % 4));
      tick();
    end
    idle();
    chk("full_cnt", cnt, 8);
    srh_vld = 1'b1; srh_dat = 4'h9;
    tick();
    idle();
    chk("full_hit", rsp_hit, 1);
    chk("full_idx", rsp_idx, 1);
    chk("full_msk", rsp_msk, 8'h22);

    // clear with same-cycle write survives
    clr = 1'b1; wr_vld = 1'b1; wr_idx = 3'd5; wr_dat = 4'h1;
    tick();
    idle();
    chk("clrwr_cnt", cnt, 1);
    srh_vld = 1'b1; srh_dat = 4'h1;
    tick();
    srh_dat = 4'h8;
    chk("clrwr_hit", rsp_hit, 1);
    chk("clrwr_idx", rsp_idx, 5);
    chk("clrwr_msk", rsp_msk, 8'h20);
    tick();
    idle();
    chk("clr_miss_hit", rsp_hit, 0);
    chk("clr_miss_msk", rsp_msk, 0);

    // reset mid-operation drops pending response and same-cycle requests
    rsp_rdy = 1'b0;
    srh_vld = 1'b1; srh_dat = 4'h1;
    tick();
    chk("pend_vld", rsp_vld, 1);
    rst = 1'b1; rsp_rdy = 1'b1;
    wr_vld = 1'b1; wr_idx = 3'd0; wr_dat = 4'h1; clr = 1'b0;
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("mid_rst_vld", rsp_vld, 0);
    chk("mid_rst_cnt", cnt, 0);
    chk("mid_rst_msk", rsp_msk, 0);
    chk("mid_rst_rdy", srh_rdy, 1);
    srh_vld = 1'b1; srh_dat = 4'h1;
    tick();
    idle();
    chk("mid_rst_srch_vld", rsp_vld, 1);
    chk("mid_rst_srch_hit", rsp_hit, 0);

    // randomized traffic against a software model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_vld = '0;
    e_vld = 1'b0;
    e_hit = 1'b0;
    e_idx = '0;
    e_msk = '0;
    for (int c = 0; c < 500; c++) begin
      wr_vld  = ($urandom_range(0, 2) == 0);
      wr_idx  = 3'($urandom_range(0, 7));
      wr_dat  = 4'($urandom_range(0, 3));
      clr     = ($urandom_range(0, 24) == 0);
      srh_vld = ($urandom_range(0, 1) == 1);
      srh_dat = 4'($urandom_range(0, 3));
      rsp_rdy = ($urandom_range(0, 3) != 0);
      #1;
      pop = 0;
      for (int i = 0; i < 8; i++) pop += int'(m_vld[i]);
      chk("rnd_vld", rsp_vld, e_vld);
      chk("rnd_cnt", cnt, pop);
      chk("rnd_srh_rdy", srh_rdy, !e_vld || rsp_rdy);
      if (e_vld) begin
        chk("rnd_hit", rsp_hit, e_hit);
        chk("rnd_idx", rsp_idx, e_idx);
        chk("rnd_msk", rsp_msk, e_msk);
      end
      fire = srh_vld && (!e_vld || rsp_rdy);
      if (fire) begin
        e_vld = 1'b1;
        e_msk = '0;
        for (int i = 0; i < 8; i++) e_msk[i] = m_vld[i] && (m_ent[i] == srh_dat);
        e_hit = (e_msk != 0);
        e_idx = '0;
        for (int i = 7; i >= 0; i--) if (e_msk[i]) e_idx = 3'(i);
      end else if (rsp_rdy) begin
        e_vld = 1'b0;
      end
      if (clr) m_vld = '0;
      if (wr_vld) begin
        m_vld[wr_idx] = 1'b1;
        m_ent[wr_idx] = wr_dat;
      end
      tick();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/eql_cam.md
EQL_CAM -- requirements
Module: eql_cam

Interface
REQ-001 Parameter WIDTH, default 4: entry and search key width in bits.
REQ-002 Parameter DEPTH, default 8: number of entries (>=2); IDX_W = $clog2(DEPTH), CNT_W = $clog2(DEPTH+1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 wr_vld  input  1  write request; always accepted, no ready.
REQ-006 wr_idx  input  IDX_W  entry index to write; values >= DEPTH ignored.
REQ-007 wr_dat  input  WIDTH  entry value.
REQ-008 clr  input  1  invalidate all entries.
REQ-009 srh_vld  input  1  search request valid.
REQ-010 srh_rdy  output  1  search request ready.
REQ-011 srh_dat  input  WIDTH  search key.
REQ-012 rsp_vld  output  1  response valid.
REQ-013 rsp_rdy  input  1  response ready.
REQ-014 rsp_hit  output  1  at least one valid entry equals key.
REQ-015 rsp_idx  output  IDX_W  lowest matching index; 0 on miss.
REQ-016 rsp_msk  output  DEPTH  bit i set iff entry i valid and equal to key.
REQ-017 cnt  output  CNT_W  number of valid entries.

Function
REQ-018 Storage: DEPTH registers of WIDTH bits plus DEPTH valid bits.
REQ-019 Write: wr_vld with wr_idx<DEPTH loads wr_dat into entry wr_idx and sets its valid bit at the next edge; rewriting a valid entry overwrites it, cnt unchanged.
REQ-020 clr clears all valid bits at the next edge; clr and wr_vld in the same cycle: all cleared except wr_idx, which ends valid with wr_dat (cnt=1).
REQ-021 Search handshake: transfer when srh_vld && srh_rdy; srh_rdy = !rsp_vld || rsp_rdy (combinational, no dependency on srh_vld).
REQ-022 Latency: result registered, rsp_vld asserted the cycle after search transfer; full throughput of one search per cycle when rsp_rdy held high.
REQ-023 Search compares against entry contents and valid bits as they are before the same-cycle edge (read-before-write); a same-cycle write or clr does not affect that result.
REQ-024 Backpressure: while rsp_vld && !rsp_rdy, rsp_hit/rsp_idx/rsp_msk stay stable and no new search is accepted.
REQ-025 rsp_vld deasserts after rsp_rdy handshake unless a new search transfers in the same cycle.
REQ-026 Priority: with multiple matches rsp_idx is the lowest set bit of rsp_msk; miss gives rsp_hit=0, rsp_idx=0, rsp_msk=0.
REQ-027 cnt equals population count of valid bits, updated registered with them; never exceeds DEPTH.

Reset
REQ-028 rst clears all valid bits, cnt=0, rsp_vld=0, rsp_hit=0, rsp_idx=0, rsp_msk=0; entry data not reset.
REQ-029 rst mid-operation discards any pending response and ignores same-cycle wr_vld, clr, and search; srh_rdy=1 the cycle after reset.

Structure
REQ-030 Shared package eql_pkg holds no parameters; only the index/count width helper functions used by other blocks in the codebase.
REQ-031 Per-entry matching reuses the existing eql_cmp module, one instance per entry, ANDed with the valid bit; the priority encoding of the match vector stays inline.

Verification
REQ-032 Reset then search 4'h5 -> rsp_vld next cycle, rsp_hit=0, rsp_idx=0, rsp_msk=0, cnt=0.
REQ-033 Write 4'hA to idx 2 and 6, search 4'hA -> rsp_hit=1, rsp_idx=2, rsp_msk=8'b0100_0100, cnt=2.
REQ-034 Write idx 3 = 4'h7 and search 4'h7 same cycle -> miss; repeat search next cycle -> hit idx 3.
REQ-035 Hold rsp_rdy=0 for 3 cycles with srh_vld=1 -> srh_rdy=0, outputs stable, one response per accepted search after release, none lost or duplicated.
REQ-036 Fill all 8 entries, then clr with wr_vld idx 5 = 4'h1 -> cnt=1; search 4'h1 -> hit idx 5.
REQ-037 Randomized writes/clr/searches with random rsp_rdy against a software model of entries -> every response matches the model's msk/idx/hit.
